// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI poller.
// Parameter defaults live in the modules that use them.
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } jstk_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
  } jstk_sample_t;

  localparam int         JSTK_NBYTES   = 5;
  localparam logic [7:0] JSTK_CMD_BASE = 8'h80;
  localparam logic [9:0] JSTK_CENTER   = 10'd512;

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: one byte per start, 16 half-periods long,
// the last half-period held low so byte time is 16*SCLK_HALF.
module spi_byte_shifter #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       start,
  input  logic       miso,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi
);

  localparam int HW = $clog2(SCLK_HALF);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [3:0]    half_q, half_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          half_end;

  assign half_end = busy_q && (hcnt_q == HW'(SCLK_HALF - 1));
  assign done     = half_end && (half_q == 4'd15);
  assign rx_byte  = rx_q;
  assign sclk     = sclk_q;
  assign mosi     = tx_q[7];

  always_comb begin
    hcnt_d = hcnt_q;
    half_d = half_q;
    busy_d = busy_q;
    sclk_d = sclk_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (load) begin
      tx_d = tx_byte;
    end
    // start raises SCLK immediately: first rise lands on the start edge
    if (start) begin
      busy_d = 1'b1;
      sclk_d = 1'b1;
      hcnt_d = '0;
      half_d = 4'd0;
      rx_d   = {rx_q[6:0], miso};
    end else if (busy_q) begin
      if (half_end) begin
        hcnt_d = '0;
        if (half_q == 4'd15) begin
          busy_d = 1'b0;
        end else begin
          half_d = half_q + 4'd1;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            tx_d = {tx_q[6:0], 1'b0};
          end else begin
            rx_d = {rx_q[6:0], miso};
          end
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hcnt_q <= '0;
      half_q <= 4'd0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
    end else begin
      hcnt_q <= hcnt_d;
      half_q <= half_d;
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/pmod_jstk_reader.sv
// Polls the PmodJSTK with a 5-byte SPI transaction every POLL_CYC clocks
// and publishes a registered X/Y/button sample with a one-cycle strobe.
module pmod_jstk_reader #(
  parameter int SCLK_HALF = 50,
  parameter int SS_SETUP  = 1500,
  parameter int BYTE_GAP  = 1000,
  parameter int POLL_CYC  = 1_000_000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  output logic [9:0] joy_x,
  output logic [9:0] joy_y,
  output logic [2:0] btn,
  output logic       sample_valid
);

  import jstk_pkg::*;

  localparam int PW   = $clog2(POLL_CYC);
  localparam int WMAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int WW   = $clog2(WMAX + 1);

  jstk_state_e  state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [2:0]   idx_q, idx_d;
  jstk_sample_t cap_q, cap_d;
  jstk_sample_t out_q, out_d;
  logic         ss_q, ss_d;
  logic         valid_q, valid_d;

  logic         wrap;
  logic [WW-1:0] wlast;
  logic         load, start, done;
  logic [7:0]   tx_byte, rx_byte;

  spi_byte_shifter #(
    .SCLK_HALF(SCLK_HALF)
  ) u_shift (
    .clk    (clk),
    .clr_n  (clr_n),
    .load   (load),
    .tx_byte(tx_byte),
    .start  (start),
    .miso   (miso),
    .done   (done),
    .rx_byte(rx_byte),
    .sclk   (sclk),
    .mosi   (mosi)
  );

  assign wrap   = (poll_q == PW'(POLL_CYC - 1));
  assign poll_d = wrap ? '0 : poll_q + 1'b1;
  assign wlast  = (state_q == ST_SETUP) ? WW'(SS_SETUP - 1)
                                        : WW'(BYTE_GAP - 1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    out_d   = out_q;
    ss_d    = ss_q;
    valid_d = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    tx_byte = 8'h00;
    unique case (state_q)
      // wraps seen outside IDLE are dropped, never queued
      ST_IDLE: begin
        if (wrap) begin
          state_d = ST_SETUP;
          ss_d    = 1'b0;
          wcnt_d  = '0;
          idx_d   = 3'd0;
          load    = 1'b1;
          tx_byte = JSTK_CMD_BASE | {6'b0, led};
        end
      end
      ST_SETUP, ST_GAP: begin
        if (wcnt_q == wlast) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (done) begin
          case (idx_q)
            3'd0:    cap_d.x[7:0] = rx_byte;
            3'd1:    cap_d.x[9:8] = rx_byte[1:0];
            3'd2:    cap_d.y[7:0] = rx_byte;
            3'd3:    cap_d.y[9:8] = rx_byte[1:0];
            default: cap_d.btn    = rx_byte[2:0];
          endcase
          idx_d  = idx_q + 3'd1;
          wcnt_d = '0;
          if (idx_q == 3'(JSTK_NBYTES - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            load    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        ss_d    = 1'b1;
        valid_d = 1'b1;
        out_d   = cap_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      poll_q  <= '0;
      wcnt_q  <= '0;
      idx_q   <= 3'd0;
      cap_q   <= '0;
      out_q   <= '{x: JSTK_CENTER, y: JSTK_CENTER, btn: 3'b000};
      ss_q    <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      ss_q    <= ss_d;
      valid_q <= valid_d;
    end
  end

  assign ss           = ss_q;
  assign joy_x        = out_q.x;
  assign joy_y        = out_q.y;
  assign btn          = out_q.btn;
  assign sample_valid = valid_q;

endmodule

// File: doc/pmod_jstk_reader.md
# pmod_jstk_reader

SPI master that polls the PmodJSTK joystick and produces the `joy_x`/`joy_y` samples consumed by the cursor-update logic. It runs one 5-byte full-duplex transaction per poll period and drives the LED command byte. It captures X, Y and button data, then presents a registered sample with a one-cycle valid strobe. It sits between the Pmod connector pins and the dot-position updaters.

## Interface

Parameters:
- `SCLK_HALF`, 50: system clocks per SCLK half-period (100 MHz → 1 MHz SCLK); minimum 2.
- `SS_SETUP`, 1500: clocks from `ss` low to the first SCLK rising edge (15 µs).
- `BYTE_GAP`, 1000: clocks of SCLK-idle between bytes (10 µs).
- `POLL_CYC`, 1_000_000: clocks from one transaction start to the next (10 ms); must exceed the transaction length.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `led`  in  2  PmodJSTK LED bits; sampled when `ss` falls.
- `miso`  in  1  SPI data from the joystick.
- `sclk`  out  1  SPI clock, mode 0 (idle low).
- `mosi`  out  1  SPI data to the joystick, MSB first.
- `ss`  out  1  slave select, active low.
- `joy_x`  out  10  last X sample, 0..1023.
- `joy_y`  out  10  last Y sample, 0..1023.
- `btn`  out  3  last button state {trigger, btn2, btn1}.
- `sample_valid`  out  1  one-cycle pulse when `joy_x`/`joy_y`/`btn` update.

## Operation

- Reset values: `ss`=1, `sclk`=0, `mosi`=0, `joy_x`=512, `joy_y`=512 (centered, inside the cursor dead zone), `btn`=0, `sample_valid`=0. The poll counter is cleared and the FSM enters IDLE.
- FSM states and transitions:
  - IDLE → SETUP when the poll counter reaches `POLL_CYC`-1. The counter wraps to 0 on that cycle and runs continuously.
  - SETUP: `ss`=0. Count `SS_SETUP` clocks, then go to SHIFT.
  - SHIFT: 8 bits. `sclk` toggles every `SCLK_HALF` clocks. `miso` is sampled into the receive shifter on each SCLK rise. `mosi` is updated on each SCLK fall, and bit 7 is presented on entry to SHIFT. After the 8th fall, store the byte and increment the byte index. Go to GAP if the index is below 5, otherwise to DONE.
  - GAP: `sclk`=0 and `ss`=0 for `BYTE_GAP` clocks, then back to SHIFT.
  - DONE (1 cycle): `ss`=1, outputs update, `sample_valid`=1, then go to IDLE.
- Transmit bytes: byte 0 = 0x80 | `led`, latched at SETUP entry. Bytes 1–4 = 0x00.
- Receive mapping: b0 = X[7:0], b1[1:0] = X[9:8], b2 = Y[7:0], b3[1:0] = Y[9:8], b4[2:0] = `btn`. Upper bits of b1, b3 and b4 are ignored.
- `joy_x`, `joy_y` and `btn` hold between DONE cycles and never show partial data.
- A `led` change mid-transaction affects only the next transaction.
- `clr_n` low mid-transaction: immediate abort to reset values (`ss` high, `sclk` low). Captured bytes are discarded. Polling restarts from counter 0.
- If the poll counter wraps while a transaction is in flight, the wrap is ignored and no transaction queues. The next start is at the following wrap.

## Timing

- SCLK period = 2·`SCLK_HALF` clocks. The first SCLK rise comes exactly `SS_SETUP` clocks after `ss` falls.
- Byte time = 16·`SCLK_HALF` clocks. Transaction = `SS_SETUP` + 5·16·`SCLK_HALF` + 4·`BYTE_GAP` + 1 clocks.
- `sample_valid` and the new output values appear on the same clock edge, the one on which `ss` returns high.
- Between transactions `sclk`=0 and `mosi`=0.

## Structure

- Shared package `jstk_pkg`: FSM state enum, `JSTK_NBYTES`=5, `JSTK_CMD_BASE`=8'h80, `JSTK_CENTER`=10'd512. Parameter defaults stay in the module.
- One sub-module, `spi_byte_shifter`, handles the 8-bit mode-0 shift. It has load, start and done ports plus the tx and rx bytes, and owns the SCLK half-period counter. The top module owns the poll counter, the FSM, the byte index and the output registers.

## Test plan

All scenarios use `SCLK_HALF`=4, `SS_SETUP`=20, `BYTE_GAP`=16, `POLL_CYC`=1000.

- Reset: hold `clr_n`=0 for 5 clocks → `joy_x`=512, `joy_y`=512, `btn`=0, `ss`=1, `sclk`=0, no `sample_valid` before the first poll wrap.
- Full transaction: slave model returns 0x34,0x02,0xC8,0x01,0x05 → `joy_x`=564, `joy_y`=456, `btn`=3'b101, one `sample_valid` pulse. Exactly 40 SCLK rises, 5 groups of 8.
- Command byte: `led`=2'b10 at SETUP entry, changed to 2'b01 during byte 0 → MOSI byte 0 = 0x82, bytes 1–4 = 0x00. The next transaction sends 0x81.
- Timing: measure `ss` fall to first SCLK rise = 20 clocks, SCLK period = 8 clocks, last fall of byte n to first rise of byte n+1 = 16 + 4 clocks. `sample_valid` fires exactly 1000 clocks apart across consecutive transactions.
- Edge values: X = 1023 and Y = 0 (bytes 0xFF,0xFF,0x00,0xFC,0xF8) → `joy_x`=1023, `joy_y`=0, `btn`=0; masked bits ignored.
- Reset mid-transaction: assert `clr_n` during byte 3 → `ss`=1 immediately, outputs return to 512/512/0 and no `sample_valid`. After release, the next transaction starts 1000 clocks later and completes normally.
